clk_div_n: RTL and testbench
============================

Name: clk_div_n

Overview:
- Parametrised integer clock divider; successor to the fixed divide-by-2 block.
- Divides `clk` by a runtime-programmable ratio N from 2 to 2^WIDTH-1.
- Odd ratios can produce a 50% duty output.
- Divisor changes are glitch-free: a new value is applied only at a period boundary.
- Also produces `tick`, a one-cycle pulse at the start of each output period, for downstream logic that must stay in the `clk` domain.

Parameters:
- WIDTH, 8, width of the divisor and the internal counter.
- DEFAULT_DIV, 2, divisor loaded on reset. Must be >= 2 and < 2^WIDTH.

Ports:
- clk  in  1  input clock.
- rst  in  1  asynchronous, active-low reset. Low = reset.
- en  in  1  run enable, level-sensitive.
- div_val  in  WIDTH  requested divisor N.
- div_load  in  1  one-cycle strobe; captures `div_val`.
- div_busy  out  1  high while a captured divisor is waiting to be applied.
- clk_out  out  1  divided clock.
- tick  out  1  one-`clk`-cycle pulse, coincident with each rising edge of `clk_out`.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - `cnt`=N-1 (parked), active divisor=DEFAULT_DIV, pending divisor cleared.
  - `div_busy`=0, `clk_out`=0, `tick`=0, negedge helper flop=0.
  - `clk_out` falls immediately when reset asserts, including mid-period.
- Counter `cnt`, posedge, range 0..N-1:
  - Next value = (`cnt`==N-1) ? 0 : `cnt`+1.
  - `tick` <= (next `cnt`==0).
- Registered high phase `pos_q` <= (next `cnt` < H):
  - Even N: H=N/2.
  - Odd N: H=(N-1)/2.
- Output:
  - Even N: `clk_out`=`pos_q`.
  - Odd N: see Optional Feature.
- Timing after reset release with `en`=1:
  - First posedge: `cnt` goes to 0, `clk_out` rises, `tick`=1.
  - Latency from first enabled edge to `clk_out` high is one `clk` edge.
- FSM states: IDLE (parked at `cnt`=N-1, `clk_out` low), RUN, STOP.
  - IDLE -> RUN: `en`=1 at a posedge; that edge starts period 0.
  - RUN -> STOP: `en`=0.
  - STOP -> IDLE: the current period finishes normally; at the wrap edge the block parks instead of starting a new period. It never truncates a high phase.
  - STOP -> RUN: `en`=1 again before the wrap; counting continues seamlessly with no extra edge.
- Divisor capture:
  - A `div_load` edge writes `div_val` into the pending register and sets `div_busy`.
  - Values 0 and 1 are clamped to 2 at capture.
- Divisor apply:
  - Applied at the next wrap edge (`cnt`==N-1 while in RUN), or at the next edge when in IDLE.
  - `div_busy` clears on the apply edge. The new period starts with the new N.
- Simultaneous events:
  - `div_load` while `div_busy`=1: the pending value is overwritten; last write wins.
  - `div_load` on an apply edge: the newly presented `div_val` is the one applied, and `div_busy` stays 0.
- Arithmetic:
  - All comparisons are unsigned, WIDTH bits.
  - Maximum N=2^WIDTH-1 (255 at default WIDTH); no overflow path.

Optional Feature:
- Macro: CLK_DIV_ODD50_EN.
- Defined:
  - Adds a negedge-clocked flop `neg_q` <= `pos_q`, reset to 0 by `rst`.
  - For odd N: `clk_out` = `pos_q` | `neg_q`, giving a high time of exactly N/2 `clk` periods (50% duty).
  - For even N: `neg_q` is masked, so `clk_out`=`pos_q`.
- Undefined:
  - No negedge logic.
  - For odd N: `clk_out`=`pos_q`, high for (N-1)/2 of N cycles (e.g. N=3 gives 1 high, 2 low).
  - `tick` timing is identical in both builds.

Test Plan (20 ns `clk` period):
- Reset low for 20 ns, then `en`=1 with default N=2:
  - `clk_out` has a 40 ns period, 20 ns high.
  - `tick` pulses every 2 cycles.
  - First rise is on the first posedge after release.
- Load N=5 mid-period:
  - `div_busy`=1 until the next wrap, then 0.
  - With CLK_DIV_ODD50_EN: 100 ns period, 50 ns high.
  - Without it: 100 ns period, 40 ns high.
- `div_val`=0 then `div_val`=1, each loaded:
  - Both behave as N=2 (40 ns period).
  - No stuck output and no zero-length pulse.
- N=4, `en` dropped one cycle into the high phase:
  - High phase completes (40 ns), then `clk_out` parks low with `tick`=0.
  - Re-raising `en` gives a rise on the next posedge.
- Async `rst` asserted mid-high with N=6:
  - `clk_out`, `tick` and `div_busy` go to 0 without waiting for a `clk` edge.
  - After release, N=DEFAULT_DIV (2).
- Back-to-back `div_load` of 3 then 7 before the wrap with N=8:
  - Only 7 is applied at the wrap; no 3-cycle period appears.
  - `div_busy` stays high continuously until the wrap.

Source files
------------

// File: rtl/clk_div_n.sv
// Programmable integer clock divider (N = 2 .. 2^WIDTH-1) with glitch-free divisor update and a clk-domain tick.
// Define CLK_DIV_ODD50_EN to add a negedge flop that stretches odd-N high phases to 50% duty.
module clk_div_n #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             clk_out,
    output logic             tick
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [WIDTH-1:0] DEF_N    = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_LAST = WIDTH'(DEFAULT_DIV - 1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             pos_q;

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] n_next;
    logic [WIDTH-1:0] cnt_next;
    logic             apply;

    always_comb begin
        load_val = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;
        // Parked IDLE sits at N-1, so a wrap edge and an IDLE edge are both period boundaries.
        apply    = (state == IDLE) || (cnt == div_act - WIDTH'(1));
        n_next   = div_act;
        if (apply) begin
            if (div_load)
                n_next = load_val;
            else if (div_busy)
                n_next = div_pend;
        end
        if (apply)
            cnt_next = en ? '0 : n_next - WIDTH'(1);
        else
            cnt_next = cnt + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= DEF_LAST;
            div_act  <= DEF_N;
            div_pend <= '0;
            div_busy <= 1'b0;
            pos_q    <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (apply)
                state <= en ? RUN : IDLE;
            else
                state <= en ? RUN : STOP;
            cnt     <= cnt_next;
            div_act <= n_next;
            if (apply) begin
                div_busy <= 1'b0;
            end else if (div_load) begin
                div_pend <= load_val;
                div_busy <= 1'b1;
            end
            // N>>1 equals N/2 for even N and (N-1)/2 for odd N; the parked count never falls below it.
            pos_q <= (cnt_next < (n_next >> 1));
            tick  <= (cnt_next == '0);
        end
    end

`ifdef CLK_DIV_ODD50_EN
    logic neg_q;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst)
            neg_q <= 1'b0;
        else
            neg_q <= pos_q;
    end

    always_comb clk_out = pos_q | (div_act[0] & neg_q);
`else
    always_comb clk_out = pos_q;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Bench for clk_div_n: directed scenarios plus random traffic against a period-position reference model.
module tb_clk_div_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_busy;
    logic       clk_out;
    logic       tick;

    int n_asr  = 0;
    int n_fail = 0;

    // Reference: whether periods are being produced, position inside the period, active N, pending N.
    bit m_act;
    int m_pos;
    int m_n;
    bit m_pv;
    int m_pend;

    clk_div_n #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_busy (div_busy),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asr++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_pos  = 0;
        m_n    = 2;
        m_pv   = 1'b0;
        m_pend = 0;
    endtask

    task automatic model_edge(input bit e, input bit l, input int v);
        bit ap;
        int nv;
        nv = (v < 2) ? 2 : v;
        ap = !m_act || (m_pos == m_n - 1);
        if (!m_act) begin
            if (e) begin
                m_act = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == m_n - 1) begin
            if (e) m_pos = 0;
            else   m_act = 1'b0;
        end else begin
            m_pos++;
        end
        if (ap) begin
            if (l)         m_n = nv;
            else if (m_pv) m_n = m_pend;
            m_pv = 1'b0;
        end else if (l) begin
            m_pend = nv;
            m_pv   = 1'b1;
        end
    endtask

    // Expected output for half-cycle k (0 after posedge, 1 after negedge) of the current position.
    function automatic bit exp_clk(input int k);
        int lim;
`ifdef CLK_DIV_ODD50_EN
        lim = m_n;
`else
        lim = (m_n / 2) * 2;
`endif
        return m_act && ((2 * m_pos + k) < lim);
    endfunction

    task automatic step(input bit e, input bit l, input int v);
        en       = e;
        div_load = l;
        div_val  = v[7:0];
        @(posedge clk);
        model_edge(e, l, v);
        #1;
        chk("clk_out_rise_half", {31'd0, clk_out}, {31'd0, exp_clk(0)});
        chk("tick", {31'd0, tick}, {31'd0, m_act && (m_pos == 0)});
        chk("div_busy", {31'd0, div_busy}, {31'd0, m_pv});
        @(negedge clk);
        #1;
        chk("clk_out_fall_half", {31'd0, clk_out}, {31'd0, exp_clk(1)});
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        model_reset();
        #1;
        chk("reset_clk_out", {31'd0, clk_out}, 32'd0);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        chk("reset_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Default N=2, first rise on the first enabled edge
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Load 5 mid-period
        step(1, 1, 5);
        for (int i = 0; i < 12; i++) step(1, 0, 0);

        // Clamped divisors 0 and 1
        step(1, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(1, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);

        // N=4, drop en one cycle into the high phase, then re-enable
        step(1, 1, 4);
        for (int i = 0; i < 20 && !(m_act && m_pos == 0 && m_n == 4); i++) step(1, 0, 0);
        chk("n4_aligned", m_n, 4);
        for (int i = 0; i < 7; i++) step(0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // N=6, async reset in the high phase with a pending load
        step(1, 1, 6);
        for (int i = 0; i < 20 && !(m_act && m_pos == 0 && m_n == 6); i++) step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 9);
        chk("pre_rst_clk_out", {31'd0, clk_out}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_clk_out", {31'd0, clk_out}, 32'd0);
        chk("async_tick", {31'd0, tick}, 32'd0);
        chk("async_busy", {31'd0, div_busy}, 32'd0);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // N=8, back-to-back loads of 3 then 7 before the wrap
        step(1, 1, 8);
        for (int i = 0; i < 20 && !(m_act && m_pos == 0 && m_n == 8); i++) step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 3);
        step(1, 1, 7);
        for (int i = 0; i < 18; i++) step(1, 0, 0);
        chk("n7_applied", m_n, 7);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit l;
            int v;
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 19) == 0) ? $urandom_range(13, 40) : $urandom_range(0, 12);
            step(e, l, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
        $finish;
    end

endmodule
